ysyx_25020037_axil_sram: RTL and testbench
==========================================

YSYX_25020037_AXIL_SRAM -- requirements
Module: ysyx_25020037_axil_sram

Interface
REQ-001 The block SHALL have parameters, one per line:
  BASE, 32'h8000_0000, byte address of word 0
  DEPTH, 4096, number of 32-bit words, power of two
  LATENCY, 1, wait cycles between address acceptance and response, range 0..15
REQ-002 The block SHALL have the following ports, one per line:
  clk  input  1  clock
  rst  input  1  reset, asynchronous, active-high
  araddr  input  32  read address
  arvalid  input  1  read address valid
  arready  output  1  read address ready
  rdata  output  32  read data
  rresp  output  2  read response
  rvalid  output  1  read data valid
  rready  input  1  read data ready
  awaddr  input  32  write address
  awvalid  input  1  write address valid
  awready  output  1  write address ready
  wdata  input  32  write data
  wstrb  input  4  byte enables
  wvalid  input  1  write data valid
  wready  output  1  write data ready
  bresp  output  2  write response
  bvalid  output  1  write response valid
  bready  input  1  write response ready

Function
REQ-003 Read and write paths SHALL be independent FSMs, each with states IDLE, WAIT, RESP.
REQ-004 Read: arready = 1 only in IDLE; on arvalid&&arready, latch araddr, load the delay counter, go to WAIT.
REQ-005 Read WAIT SHALL last exactly LATENCY cycles, then sample memory into rdata, assert rvalid, go to RESP; LATENCY=0 SHALL pass WAIT in one cycle, so rvalid rises on the 2nd edge after acceptance.
REQ-006 Read RESP: rvalid, rdata and rresp SHALL hold stable until rvalid&&rready, then rvalid = 0 and FSM = IDLE; no new AR accepted in that cycle.
REQ-007 Write: in IDLE, awready and wready SHALL each be 1 until their own handshake; AW and W MAY complete in either order or the same cycle; WAIT SHALL begin once both are latched.
REQ-008 Write WAIT SHALL last LATENCY cycles, then commit the bytes selected by wstrb (bit i -> byte i), assert bvalid, go to RESP; bvalid SHALL hold until bready, then FSM = IDLE.
REQ-009 Word index SHALL be (addr - BASE) >> 2; addr[1:0] SHALL be ignored.
REQ-010 An address outside [BASE, BASE + 4*DEPTH) SHALL give response 2'b11 (DECERR), rdata = 32'h0, and no memory write; otherwise the response SHALL be 2'b00.
REQ-011 When a read sample and a write commit hit the same word in the same cycle, the read SHALL return the pre-write data.
REQ-012 wstrb = 4'b0000 SHALL give OKAY with memory unchanged.

Reset
REQ-013 While rst = 1, both FSMs SHALL be IDLE and arready = 1, awready = 1, wready = 1, rvalid = 0, bvalid = 0, rdata = 0, rresp = 0, bresp = 0.
REQ-014 Reset mid-transaction SHALL abandon that transaction with no memory write; memory contents SHALL NOT be reset.

Configuration
REQ-015 With YSYX_25020037_SRAM_LFSR_DELAY_EN defined, the WAIT length SHALL be {LFSR[3:0]} cycles instead of LATENCY.
  The LFSR SHALL be a 16-bit x^16+x^14+x^13+x^11+1 register, seed 16'hACE1 on reset, stepped every cycle, with one shared LFSR for both paths.
REQ-016 Without the macro, the WAIT length SHALL be exactly LATENCY cycles and no LFSR SHALL exist.

Structure
REQ-017 A shared package SHALL hold the response codes (OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11), the FSM state encodings and the default BASE.
REQ-018 The LFSR SHALL be a sub-module, ysyx_25020037_lfsr16; the memory array SHALL stay inline.

Verification
REQ-019 Write 0x80000010 = 32'hDEADBEEF with wstrb = 4'hF, then read 0x80000010 -> bresp = 00, rdata = 32'hDEADBEEF, rresp = 00.
REQ-020 Partial write with wstrb = 4'b0101 and wdata = 32'h11223344 over 32'hDEADBEEF -> read returns 32'hDE22BE44.
REQ-021 With LATENCY = 3 and rready held low 5 cycles after rvalid: rvalid rises 4 edges after the AR handshake, then rdata stays stable until rready = 1.
REQ-022 W presented 2 cycles before AW -> wready drops after the W handshake, bvalid rises only after AW plus LATENCY, and the write lands correctly.
REQ-023 Read 0x7FFFFFFC and write 0x80004000 (DEPTH = 4096) -> rresp = 11 with rdata = 0, bresp = 11, and memory unchanged.
REQ-024 Assert rst during read WAIT -> rvalid stays 0 and arready = 1 on the first cycle after release; with the macro defined, 100 reads show more than one distinct latency.

Source files
------------

// File: rtl/ysyx_25020037_axil_sram_pkg.sv
// Shared definitions for the AXI-Lite SRAM slave: response codes,
// FSM state encoding and the default base address.
package ysyx_25020037_axil_sram_pkg;

  localparam logic [31:0] DEFAULT_BASE = 32'h8000_0000;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/ysyx_25020037_lfsr16.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), seed 16'hACE1,
// stepped every cycle; its low nibble is the random wait length.
module ysyx_25020037_lfsr16 (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] dly
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        fb;

  always_comb begin
    fb     = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    lfsr_d = {fb, lfsr_q[15:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 16'hACE1;
    else     lfsr_q <= lfsr_d;
  end

  assign dly = lfsr_q[3:0];

endmodule

// File: rtl/ysyx_25020037_axil_sram.sv
// AXI-Lite SRAM slave with independent read/write FSMs and a fixed wait.
// Define YSYX_25020037_SRAM_LFSR_DELAY_EN for LFSR-driven wait lengths.
module ysyx_25020037_axil_sram
  import ysyx_25020037_axil_sram_pkg::*;
#(
  parameter logic [31:0] BASE    = DEFAULT_BASE,
  parameter int          DEPTH   = 4096,
  parameter int          LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH);

  logic [3:0] dly;

`ifdef YSYX_25020037_SRAM_LFSR_DELAY_EN
  ysyx_25020037_lfsr16 u_lfsr (
    .clk (clk),
    .rst (rst),
    .dly (dly)
  );
`else
  assign dly = 4'(LATENCY);
`endif

  logic [31:0] mem [DEPTH];

  // Offset wraps for addresses below BASE, so one compare covers both ends.
  logic [31:0] ar_off;
  logic [31:0] aw_off;
  assign ar_off = araddr - BASE;
  assign aw_off = awaddr - BASE;

  state_e        rs_q, rs_d;
  logic [AW-1:0] ar_idx_q, ar_idx_d;
  logic          ar_ok_q, ar_ok_d;
  logic [3:0]    rcnt_q, rcnt_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;

  always_comb begin
    rs_d     = rs_q;
    ar_idx_d = ar_idx_q;
    ar_ok_d  = ar_ok_q;
    rcnt_d   = rcnt_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    unique case (rs_q)
      ST_IDLE: begin
        if (arvalid) begin
          rs_d     = ST_WAIT;
          ar_idx_d = ar_off[AW+1:2];
          ar_ok_d  = ar_off < SPAN;
          rcnt_d   = dly;
        end
      end
      ST_WAIT: begin
        if (rcnt_q <= 4'd1) begin
          rs_d    = ST_RESP;
          rdata_d = ar_ok_q ? mem[ar_idx_q] : 32'h0;
          rresp_d = ar_ok_q ? RESP_OKAY : RESP_DECERR;
        end else begin
          rcnt_d = rcnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (rready) rs_d = ST_IDLE;
      end
      default: rs_d = ST_IDLE;
    endcase
  end

  state_e        ws_q, ws_d;
  logic          aw_got_q, aw_got_d;
  logic          w_got_q, w_got_d;
  logic [AW-1:0] aw_idx_q, aw_idx_d;
  logic          aw_ok_q, aw_ok_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic [1:0]    bresp_q, bresp_d;
  logic          mem_we;

  always_comb begin
    ws_d     = ws_q;
    aw_got_d = aw_got_q;
    w_got_d  = w_got_q;
    aw_idx_d = aw_idx_q;
    aw_ok_d  = aw_ok_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    wcnt_d   = wcnt_q;
    bresp_d  = bresp_q;
    mem_we   = 1'b0;
    unique case (ws_q)
      ST_IDLE: begin
        if (awvalid && !aw_got_q) begin
          aw_got_d = 1'b1;
          aw_idx_d = aw_off[AW+1:2];
          aw_ok_d  = aw_off < SPAN;
        end
        if (wvalid && !w_got_q) begin
          w_got_d = 1'b1;
          wdata_d = wdata;
          wstrb_d = wstrb;
        end
        if (aw_got_d && w_got_d) begin
          ws_d     = ST_WAIT;
          wcnt_d   = dly;
          aw_got_d = 1'b0;
          w_got_d  = 1'b0;
        end
      end
      ST_WAIT: begin
        if (wcnt_q <= 4'd1) begin
          ws_d    = ST_RESP;
          mem_we  = aw_ok_q;
          bresp_d = aw_ok_q ? RESP_OKAY : RESP_DECERR;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (bready) ws_d = ST_IDLE;
      end
      default: ws_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_q     <= ST_IDLE;
      ar_idx_q <= '0;
      ar_ok_q  <= 1'b0;
      rcnt_q   <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      ws_q     <= ST_IDLE;
      aw_got_q <= 1'b0;
      w_got_q  <= 1'b0;
      aw_idx_q <= '0;
      aw_ok_q  <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      wcnt_q   <= '0;
      bresp_q  <= RESP_OKAY;
    end else begin
      rs_q     <= rs_d;
      ar_idx_q <= ar_idx_d;
      ar_ok_q  <= ar_ok_d;
      rcnt_q   <= rcnt_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      ws_q     <= ws_d;
      aw_got_q <= aw_got_d;
      w_got_q  <= w_got_d;
      aw_idx_q <= aw_idx_d;
      aw_ok_q  <= aw_ok_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      wcnt_q   <= wcnt_d;
      bresp_q  <= bresp_d;
    end
  end

  // Contents survive reset; a same-edge read sample sees the old word.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[aw_idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign arready = (rs_q == ST_IDLE);
  assign rvalid  = (rs_q == ST_RESP);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign awready = (ws_q == ST_IDLE) && !aw_got_q;
  assign wready  = (ws_q == ST_IDLE) && !w_got_q;
  assign bvalid  = (ws_q == ST_RESP);
  assign bresp   = bresp_q;

endmodule

// File: tb/tb_ysyx_25020037_axil_sram.sv
// Randomized bench for ysyx_25020037_axil_sram against a word-array
// model of the memory, plus directed corner cases.
module tb_ysyx_25020037_axil_sram;

  localparam logic [31:0] BASE    = 32'h8000_0000;
  localparam int          DEPTH   = 4096;
  localparam int          LAT     = 3;
  localparam int          EXP_LAT = (LAT < 1) ? 1 : LAT;

  logic        clk;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  ysyx_25020037_axil_sram #(
    .BASE    (BASE),
    .DEPTH   (DEPTH),
    .LATENCY (LAT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  r;
  } rexp_t;

  bit [31:0]   mdl [int];
  rexp_t       rq [$];
  logic [1:0]  bq [$];
  bit          lat_seen [16];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out (t=%0t)", nm, $time);
  endtask

  function automatic bit inr(input logic [31:0] a);
    longint lo, hi;
    lo = longint'(BASE);
    hi = lo + 4 * longint'(DEPTH);
    return longint'(a) >= lo && longint'(a) < hi;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Compare process: response payloads against the model's queues.
  rexp_t       re;
  logic [1:0]  be;
  logic [31:0] prd;
  logic        prv;
  logic        prr;

  always @(negedge clk) begin
    if (!rst) begin
      if (rvalid && prv && !prr) chk("rdata_hold", rdata, prd);
      if (rvalid && rready) begin
        if (rq.size() == 0) fail("r_unexpected");
        else begin
          re = rq.pop_front();
          chk("rdata", rdata, re.d);
          chk("rresp", 32'(rresp), 32'(re.r));
        end
      end
      if (bvalid && bready) begin
        if (bq.size() == 0) fail("b_unexpected");
        else begin
          be = bq.pop_front();
          chk("bresp", 32'(bresp), 32'(be));
        end
      end
    end
    prv <= rvalid && !rst;
    prr <= rready;
    prd <= rdata;
  end

  task automatic do_read(input logic [31:0] a, input int hold,
                         output logic [31:0] got);
    rexp_t e;
    int    acc;
    int    n;
    e.d = inr(a) ? mdl[widx(a)] : 32'h0;
    e.r = inr(a) ? 2'b00 : 2'b11;
    rq.push_back(e);
    got = 32'hx;
    araddr  = a;
    arvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!arready && n < 50);
    if (!arready) begin
      fail("ar_handshake");
      arvalid = 1'b0;
      void'(rq.pop_back());
      return;
    end
    @(posedge clk);
    #1;
    acc     = cyc;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!rvalid) begin
      fail("rvalid_wait");
      void'(rq.pop_back());
      return;
    end
`ifndef YSYX_25020037_SRAM_LFSR_DELAY_EN
    chk("r_latency", 32'(cyc - acc), 32'(EXP_LAT));
`else
    lat_seen[(cyc - acc) & 15] = 1'b1;
`endif
    repeat (hold) @(posedge clk);
    if (hold > 0) #1;
    rready = 1'b1;
    got    = rdata;
    @(posedge clk);
    #1;
    rready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int gap,
                          input int bhold, output logic [1:0] got);
    int aw_at;
    int w_at;
    int last;
    int n;
    bit aw_done;
    bit ok;
    aw_done = 1'b0;
    ok      = 1'b1;
    aw_at   = 0;
    w_at    = 0;
    got     = 2'bx;
    fork
      begin
        int k;
        if (gap > 0) begin
          repeat (gap) @(posedge clk);
          #1;
        end
        awaddr  = a;
        awvalid = 1'b1;
        k = 0;
        do begin
          @(negedge clk);
          k++;
        end while (!awready && k < 50);
        if (!awready) begin
          fail("aw_handshake");
          ok = 1'b0;
        end
        @(posedge clk);
        #1;
        aw_at   = cyc;
        awvalid = 1'b0;
        aw_done = 1'b1;
      end
      begin
        int k;
        if (gap < 0) begin
          repeat (-gap) @(posedge clk);
          #1;
        end
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        k = 0;
        do begin
          @(negedge clk);
          k++;
        end while (!wready && k < 50);
        if (!wready) begin
          fail("w_handshake");
          ok = 1'b0;
        end
        @(posedge clk);
        #1;
        w_at   = cyc;
        wvalid = 1'b0;
        if (!aw_done) begin
          @(negedge clk);
          if (!aw_done) chk("wready_drop", 32'(wready), 32'd0);
        end
      end
    join
    if (!ok) return;
    last = (aw_at > w_at) ? aw_at : w_at;
    if (inr(a)) mdl[widx(a)] = merge(mdl[widx(a)], d, s);
    bq.push_back(inr(a) ? 2'b00 : 2'b11);
    n = 0;
    while (!bvalid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bvalid) begin
      fail("bvalid_wait");
      void'(bq.pop_back());
      return;
    end
`ifndef YSYX_25020037_SRAM_LFSR_DELAY_EN
    chk("b_latency", 32'(cyc - last), 32'(EXP_LAT));
`endif
    repeat (bhold) @(posedge clk);
    if (bhold > 0) #1;
    got    = bresp;
    bready = 1'b1;
    @(posedge clk);
    #1;
    bready = 1'b0;
  endtask

  logic [31:0] pool [16];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] g;
    logic [1:0]  b;
    logic [31:0] a;
    int          distinct;
    rst     = 1'b1;
    araddr  = '0;
    arvalid = 1'b0;
    rready  = 1'b0;
    awaddr  = '0;
    awvalid = 1'b0;
    wdata   = '0;
    wstrb   = '0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_awready", 32'(awready), 32'd1);
    chk("rst_wready", 32'(wready), 32'd1);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    chk("rst_bresp", 32'(bresp), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full write then read back.
    do_write(32'h8000_0010, 32'hDEADBEEF, 4'hF, 0, 0, b);
    chk("w_full_bresp", 32'(b), 32'd0);
    do_read(32'h8000_0010, 0, g);
    chk("r_full_lit", g, 32'hDEADBEEF);

    // Byte lanes 0 and 2 only.
    do_write(32'h8000_0010, 32'h11223344, 4'b0101, 0, 1, b);
    do_read(32'h8000_0010, 0, g);
    chk("r_partial_lit", g, 32'hDE22BE44);

    // Empty strobe leaves the word untouched.
    do_write(32'h8000_0012, 32'hFFFF_FFFF, 4'b0000, 0, 0, b);
    chk("w_nostrb_bresp", 32'(b), 32'd0);
    do_read(32'h8000_0013, 5, g);
    chk("r_nostrb_hold5", g, 32'hDE22BE44);

    // W two cycles ahead of AW, and AW ahead of W.
    do_write(32'h8000_0020, 32'h0BAD_F00D, 4'hF, 2, 0, b);
    do_read(32'h8000_0020, 0, g);
    chk("r_wfirst_lit", g, 32'h0BAD_F00D);
    do_write(32'h8000_3FFC, 32'h1357_9BDF, 4'hF, -2, 2, b);
    do_read(32'h8000_3FFC, 1, g);
    chk("r_top_word_lit", g, 32'h1357_9BDF);

    // Out-of-range accesses.
    do_write(32'h8000_0000, 32'hCAFE_F00D, 4'hF, 0, 0, b);
    do_read(32'h7FFF_FFFC, 0, g);
    chk("r_below_lit", g, 32'h0);
    do_write(32'h8000_4000, 32'h5555_AAAA, 4'hF, 1, 0, b);
    chk("w_above_bresp", 32'(b), 32'd3);
    do_read(32'h8000_0000, 0, g);
    chk("r_word0_kept", g, 32'hCAFE_F00D);

    // Same-cycle read sample and write commit to one word.
    fork
      do_read(32'h8000_0020, 0, g);
      do_write(32'h8000_0020, 32'h7777_8888, 4'hF, 0, 0, b);
    join
    chk("r_same_cycle_old", g, 32'h0BAD_F00D);
    do_read(32'h8000_0020, 0, g);
    chk("r_same_cycle_new", g, 32'h7777_8888);

    // Reset during read WAIT.
    araddr  = 32'h8000_0010;
    arvalid = 1'b1;
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_rdata", rdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_rvalid", 32'(rvalid), 32'd0);
    chk("rel_arready", 32'(arready), 32'd1);
    @(posedge clk);
    #1;

    // Reset during write WAIT must not commit.
    awaddr  = 32'h8000_0000;
    awvalid = 1'b1;
    wdata   = 32'h9999_9999;
    wstrb   = 4'hF;
    wvalid  = 1'b1;
    @(posedge clk);
    #1;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_bvalid", 32'(bvalid), 32'd0);
    @(posedge clk);
    #1;
    do_read(32'h8000_0000, 0, g);
    chk("r_rst_nowrite", g, 32'hCAFE_F00D);

    // Randomized traffic over a small pool of words.
    for (int i = 0; i < 16; i++) begin
      pool[i] = BASE + 32'(4 * ((i * 263) % DEPTH));
      do_write(pool[i], $urandom, 4'hF, 0, 0, b);
    end
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 3))
          0: a = BASE - 32'd4;
          1: a = BASE + 32'(4 * DEPTH);
          2: a = 32'h0000_0000 | 32'($urandom_range(0, 255));
          default: a = 32'hFFFF_FFFC;
        endcase
      end else begin
        a = pool[$urandom_range(0, 15)] | 32'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 1) == 0)
        do_read(a, $urandom_range(0, 3), g);
      else
        do_write(a, $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 4) - 2, $urandom_range(0, 3), b);
    end

`ifdef YSYX_25020037_SRAM_LFSR_DELAY_EN
    distinct = 0;
    for (int i = 0; i < 16; i++) if (lat_seen[i]) distinct++;
    chk("lfsr_distinct", 32'(distinct > 1), 32'd1);
`else
    distinct = 0;
`endif

    repeat (3) @(posedge clk);
    chk("rq_drained", 32'(rq.size()), 32'd0);
    chk("bq_drained", 32'(bq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
